// File: rtl/pusch_dmrs_gen.sv
// PUSCH DMRS generator: Gold sequence c(n) from c_init, QPSK-mapped and written
// one RE per cycle into the DMRS sample memory, then a done pulse to the mapper.
module pusch_dmrs_gen #(
   parameter int DMRS_Len  = 9,
   parameter int AMP       = 181,
   parameter int NC        = 1600,
   parameter int RE_PER_RB = 6
) (
   input  logic                CLK_DMRS,
   input  logic                RST_DMRS,
   input  logic                Start,
   input  logic [30:0]         C_init,
   input  logic [6:0]          N_rb,
   output logic [DMRS_Len-1:0] Dmrs_I,
   output logic [DMRS_Len-1:0] Dmrs_Q,
   output logic                Dmrs_wr_en,
   output logic [9:0]          Dmrs_wr_addr,
   output logic                DMRS_Done,
   output logic                Busy
);

   typedef enum logic [1:0] {IDLE, WARMUP, GEN, FINISH} state_t;

   localparam logic signed [DMRS_Len-1:0] AMP_S       = DMRS_Len'(AMP);
   localparam logic [15:0]                NC_LAST     = 16'(NC - 1);
   localparam bit                         SKIP_WARMUP = (NC == 0);

   state_t                      state_q;
   logic [30:0]                 x1_q, x2_q;
   logic [15:0]                 cnt_q;
   logic [9:0]                  len_q;
   logic signed [DMRS_Len-1:0]  i_q, q_q;
   logic                        wr_en_q, done_q;
   logic [9:0]                  addr_q;
   logic [30:0]                 x1_d, x2_d;

   // Bit 0 is the oldest sequence bit; the new bit x(n+31) enters at bit 30.
   function automatic logic [30:0] x1_step(input logic [30:0] x);
      return {x[3] ^ x[0], x[30:1]};
   endfunction

   function automatic logic [30:0] x2_step(input logic [30:0] x);
      return {x[3] ^ x[2] ^ x[1] ^ x[0], x[30:1]};
   endfunction

   function automatic logic signed [DMRS_Len-1:0] qpsk(input logic c);
      return c ? -AMP_S : AMP_S;
   endfunction

   // GEN consumes two sequence bits per RE, WARMUP discards one per cycle.
   always_comb begin
      x1_d = x1_step(x1_q);
      x2_d = x2_step(x2_q);
      if (state_q == GEN) begin
         x1_d = x1_step(x1_step(x1_q));
         x2_d = x2_step(x2_step(x2_q));
      end
   end

   always_ff @(posedge CLK_DMRS or negedge RST_DMRS) begin
      if (!RST_DMRS) begin
         state_q <= IDLE;
         x1_q    <= '0;
         x2_q    <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         i_q     <= '0;
         q_q     <= '0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  x1_q  <= 31'h1;
                  x2_q  <= C_init;
                  cnt_q <= '0;
                  len_q <= 10'(N_rb * RE_PER_RB);
                  if (N_rb == '0)
                     state_q <= FINISH;
                  else if (SKIP_WARMUP)
                     state_q <= GEN;
                  else
                     state_q <= WARMUP;
               end
            end
            WARMUP: begin
               x1_q  <= x1_d;
               x2_q  <= x2_d;
               cnt_q <= cnt_q + 16'd1;
               if (cnt_q == NC_LAST) begin
                  cnt_q   <= '0;
                  state_q <= GEN;
               end
            end
            GEN: begin
               i_q     <= qpsk(x1_q[0] ^ x2_q[0]);
               q_q     <= qpsk(x1_q[1] ^ x2_q[1]);
               wr_en_q <= 1'b1;
               addr_q  <= cnt_q[9:0];
               x1_q    <= x1_d;
               x2_q    <= x2_d;
               cnt_q   <= cnt_q + 16'd1;
               if (cnt_q[9:0] == len_q - 10'd1)
                  state_q <= FINISH;
            end
            FINISH: begin
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Dmrs_I       = i_q;
   assign Dmrs_Q       = q_q;
   assign Dmrs_wr_en   = wr_en_q;
   assign Dmrs_wr_addr = addr_q;
   assign DMRS_Done    = done_q;
   assign Busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pusch_dmrs_gen.sv
// Bench for pusch_dmrs_gen: default instance (NC=1600) and a no-warmup instance
// (NC=0), checked against an array-based Gold/QPSK reference model.
module tb_pusch_dmrs_gen;

   localparam int DL  = 9;
   localparam int AMP = 181;
   localparam int NCM = 1600;
   localparam int RPB = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_m = 1'b0;
   logic        start_z = 1'b0;
   logic [30:0] c_init = '0;
   logic [6:0]  n_rb = '0;

   logic [DL-1:0] m_i, m_q, z_i, z_q;
   logic          m_wr, z_wr, m_done, z_done, m_busy, z_busy;
   logic [9:0]    m_addr, z_addr;

   int total = 0;
   int bad   = 0;

   logic [DL-1:0] ref_i[$];
   logic [DL-1:0] ref_q[$];
   logic [DL-1:0] cap_i[$];
   logic [DL-1:0] cap_q[$];

   always #5 clk = ~clk;

   pusch_dmrs_gen #(.DMRS_Len(DL), .AMP(AMP), .NC(NCM), .RE_PER_RB(RPB)) dut_m (
      .CLK_DMRS(clk), .RST_DMRS(rst_n), .Start(start_m), .C_init(c_init), .N_rb(n_rb),
      .Dmrs_I(m_i), .Dmrs_Q(m_q), .Dmrs_wr_en(m_wr), .Dmrs_wr_addr(m_addr),
      .DMRS_Done(m_done), .Busy(m_busy));

   pusch_dmrs_gen #(.DMRS_Len(DL), .AMP(AMP), .NC(0), .RE_PER_RB(RPB)) dut_z (
      .CLK_DMRS(clk), .RST_DMRS(rst_n), .Start(start_z), .C_init(c_init), .N_rb(n_rb),
      .Dmrs_I(z_i), .Dmrs_Q(z_q), .Dmrs_wr_en(z_wr), .Dmrs_wr_addr(z_addr),
      .DMRS_Done(z_done), .Busy(z_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: expand x1/x2 element by element, c(n) = x1(n+nc) ^ x2(n+nc).
   task automatic build_ref(input logic [30:0] ci, input int len_re, input int nc);
      bit x1[$];
      bit x2[$];
      bit c0, c1;
      logic [DL-1:0] pos, neg;
      pos = DL'(AMP);
      neg = DL'(-AMP);
      ref_i.delete();
      ref_q.delete();
      for (int n = 0; n < 31; n++) begin
         x1.push_back(n == 0);
         x2.push_back(ci[n]);
      end
      for (int n = 0; n < nc + 2 * len_re; n++) begin
         x1.push_back(x1[n + 3] ^ x1[n]);
         x2.push_back(x2[n + 3] ^ x2[n + 2] ^ x2[n + 1] ^ x2[n]);
      end
      for (int m = 0; m < len_re; m++) begin
         c0 = x1[2 * m + nc] ^ x2[2 * m + nc];
         c1 = x1[2 * m + 1 + nc] ^ x2[2 * m + 1 + nc];
         ref_i.push_back(c0 ? neg : pos);
         ref_q.push_back(c1 ? neg : pos);
      end
   endtask

   // Called at #1 after an edge. sel=1 drives the NC=0 instance.
   task automatic run(input bit sel, input logic [30:0] ci, input logic [6:0] nr,
                      input int reissue_k, input bit check_tail, input string tag);
      int nc, len, nwr, first_k, done_k, exp_done;
      logic wr, dn, bz;
      logic [9:0] ad;
      logic [DL-1:0] si, sq;
      nc  = sel ? 0 : NCM;
      len = int'(nr) * RPB;
      build_ref(ci, len, nc);
      cap_i.delete();
      cap_q.delete();
      c_init = ci;
      n_rb   = nr;
      if (sel) start_z = 1'b1; else start_m = 1'b1;
      @(posedge clk); #1;
      start_z = 1'b0;
      start_m = 1'b0;
      c_init  = $urandom;
      n_rb    = 7'($urandom);
      chk({tag, "_busy_after_start"}, sel ? z_busy : m_busy, 1);
      nwr = 0;
      first_k = -1;
      done_k = -1;
      for (int k = 1; k <= nc + len + 40 && done_k < 0; k++) begin
         @(posedge clk); #1;
         if (k == reissue_k) begin
            c_init = ~ci;
            n_rb   = nr + 7'd4;
            if (sel) start_z = 1'b1; else start_m = 1'b1;
         end else begin
            start_z = 1'b0;
            start_m = 1'b0;
         end
         wr = sel ? z_wr : m_wr;
         dn = sel ? z_done : m_done;
         bz = sel ? z_busy : m_busy;
         ad = sel ? z_addr : m_addr;
         si = sel ? z_i : m_i;
         sq = sel ? z_q : m_q;
         if (wr) begin
            if (nwr == 0) first_k = k;
            if (nwr < len) begin
               chk({tag, "_addr"}, ad, nwr);
               chk({tag, "_I"}, si, ref_i[nwr]);
               chk({tag, "_Q"}, sq, ref_q[nwr]);
            end
            cap_i.push_back(si);
            cap_q.push_back(sq);
            nwr++;
         end
         if (dn) begin
            done_k = k;
            chk({tag, "_busy_at_done"}, bz, 0);
         end
      end
      start_z = 1'b0;
      start_m = 1'b0;
      exp_done = (len == 0) ? 1 : nc + len + 1;
      chk({tag, "_write_count"}, nwr, len);
      if (len > 0) chk({tag, "_first_write_cycle"}, first_k, nc + 1);
      chk({tag, "_done_cycle"}, done_k, exp_done);
      if (check_tail) begin
         @(posedge clk); #1;
         chk({tag, "_done_one_cycle"}, sel ? z_done : m_done, 0);
         chk({tag, "_idle_no_write"}, sel ? z_wr : m_wr, 0);
      end
   endtask

   initial begin
      int nd, nw;
      logic [30:0] ci;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_wr", m_wr, 0);
      chk("rst_m_done", m_done, 0);
      chk("rst_m_busy", m_busy, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_I", m_i, 0);
      chk("rst_z_busy", z_busy, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // NC=0, C_init=0, N_rb=1: known first samples
      run(1'b1, 31'd0, 7'd1, 0, 1'b1, "nc0_cinit0");
      chk("nc0_w0_I", cap_i.size() > 0 ? cap_i[0] : 'x, 9'h14B);
      chk("nc0_w0_Q", cap_q.size() > 0 ? cap_q[0] : 'x, 9'h0B5);
      chk("nc0_w1_I", cap_i.size() > 1 ? cap_i[1] : 'x, 9'h0B5);
      chk("nc0_w1_Q", cap_q.size() > 1 ? cap_q[1] : 'x, 9'h0B5);

      // Reset mid-GEN with N_rb=4
      c_init  = $urandom;
      n_rb    = 7'd4;
      start_z = 1'b1;
      @(posedge clk); #1;
      start_z = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_reset_writing", z_wr, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_wr", z_wr, 0);
      chk("midrst_I", z_i, 0);
      chk("midrst_Q", z_q, 0);
      chk("midrst_addr", z_addr, 0);
      chk("midrst_done", z_done, 0);
      chk("midrst_busy", z_busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      nd = 0;
      nw = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (z_done) nd++;
         if (z_wr) nw++;
      end
      chk("post_reset_done_count", nd, 0);
      chk("post_reset_write_count", nw, 0);

      // Default NC, N_rb=100, random seed
      run(1'b0, 31'($urandom), 7'd100, 0, 1'b1, "nrb100");

      // N_rb=0: immediate done, no writes
      run(1'b0, 31'($urandom), 7'd0, 0, 1'b1, "nrb0");

      // Start re-issued during WARMUP is ignored
      run(1'b0, 31'($urandom), 7'd5, 20, 1'b1, "reissue");

      // Back-to-back requests
      ci = 31'($urandom);
      run(1'b0, ci, 7'd3, 0, 1'b0, "b2b_A");
      run(1'b0, ~ci, 7'd7, 0, 1'b1, "b2b_B");

      // Random allocations on the no-warmup instance, back to back
      for (int r = 0; r < 3; r++)
         run(1'b1, 31'($urandom), 7'($urandom_range(1, 127)), 0, r == 2, "rand_nc0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
